uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_if.sv | 20 ++
 rtl/uart_baud_cnt.sv | 36 +++
 rtl/uart_tx.sv | 134 +++++++++++++
 tb/tb_uart_tx.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity codes and defaults.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int DEF_CLKS_PER_BIT = 434;

    // Odd: ones(data) + p is odd; even: ones(data) + p is even.
    function automatic logic parity_bit(input logic [7:0] data,
                                        input int mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between on-chip logic and the UART transmitter.
interface uart_tx_if;

    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// Frame-aligned bit-period counter; pulses bit_done on the last
// cycle of each bit period. Shared with the receiver.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign bit_done = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || bit_done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-byte holding register, framing FSM,
// shift register, parity and registered serial output.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic      clk,
    input  logic      reset,
    uart_tx_if.slave  bus,
    output logic      tx,
    output logic      busy
);

    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] hold_data_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       par_q, par_d;
    logic       hold_full_q, hold_full_d;
    logic       tx_q, tx_d;
    logic       load;
    logic       accept;
    logic       bit_done;
    logic       cnt_clear;

    assign accept        = bus.din_valid && !hold_full_q;
    assign bus.din_ready = !hold_full_q;
    assign busy          = (state_q != S_IDLE) || hold_full_q;
    assign tx            = tx_q;

    // Restart the bit period on every state entry.
    assign cnt_clear = (state_q == S_IDLE) || (state_d != state_q);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .bit_done (bit_done)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        par_d       = par_q;
        hold_full_d = hold_full_q;
        load        = 1'b0;
        tx_d        = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                load = hold_full_q;
            end
            S_START: begin
                if (bit_done) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_done) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_done) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                        load      = hold_full_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            state_d     = S_START;
            shift_d     = hold_data_q;
            par_d       = parity_bit(hold_data_q, PARITY);
            bit_cnt_d   = '0;
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_full_d = 1'b1;
        end

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            par_q       <= 1'b0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            par_q       <= par_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            if (accept) begin
                hold_data_q <= bus.din;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Four differently configured transmitters checked every cycle
// against a frame-timing model, plus hand-computed waveform checks.
module tb_uart_tx;

    function automatic int cpb(input int g);
        case (g)
            0:       return 434;
            1:       return 5;
            2:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int par(input int g);
        case (g)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int stp(input int g);
        return (g >= 2) ? 2 : 1;
    endfunction

    function automatic int nbits(input int g);
        return 10 + ((par(g) != 0) ? 1 : 0) + stp(g) - 1;
    endfunction

    // Line level of bit i of a frame carrying byte b.
    function automatic logic line_bit(input int g, input logic [7:0] b,
                                      input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == 9 && par(g) != 0) return (par(g) == 2) ? ^b : ~^b;
        return 1'b1;
    endfunction

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din [4];
    logic       vld [4];
    wire  [3:0] tx;
    wire  [3:0] busy;
    wire  [3:0] rdy;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : ch
        uart_tx_if bus();
        assign bus.din       = din[g];
        assign bus.din_valid = vld[g];
        assign rdy[g]        = bus.din_ready;
        uart_tx #(
            .CLKS_PER_BIT(cpb(g)),
            .PARITY(par(g)),
            .STOP_BITS(stp(g))
        ) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.slave),
            .tx    (tx[g]),
            .busy  (busy[g])
        );
    end

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural model: frame position per channel.
    bit         m_act  [4] = '{default: 0};
    int         m_t    [4] = '{default: 0};
    logic [7:0] m_cur  [4] = '{default: 0};
    bit         m_hold [4] = '{default: 0};
    logic [7:0] m_hd   [4] = '{default: 0};

    initial begin
        forever begin
            @(posedge clk);
            for (int g = 0; g < 4; g++) begin
                bit acc, ending, start;
                if (reset) begin
                    m_act[g]  = 0;
                    m_hold[g] = 0;
                    m_t[g]    = 0;
                end else begin
                    acc    = vld[g] && !m_hold[g];
                    ending = m_act[g] &&
                             (m_t[g] == nbits(g) * cpb(g) - 1);
                    start  = m_hold[g] && (!m_act[g] || ending);
                    if (start) begin
                        m_act[g]  = 1;
                        m_t[g]    = 0;
                        m_cur[g]  = m_hd[g];
                        m_hold[g] = 0;
                    end else if (m_act[g]) begin
                        if (ending) m_act[g] = 0;
                        else m_t[g]++;
                    end
                    if (acc) begin
                        m_hold[g] = 1;
                        m_hd[g]   = din[g];
                    end
                end
            end
            #1;
            if (!reset) begin
                for (int g = 0; g < 4; g++) begin
                    logic et;
                    et = m_act[g] ?
                         line_bit(g, m_cur[g], m_t[g] / cpb(g)) : 1'b1;
                    check($sformatf("ch%0d tx/busy/ready", g),
                          32'({tx[g], busy[g], rdy[g]}),
                          32'({et, m_act[g] || m_hold[g], !m_hold[g]}));
                end
            end
        end
    end

    // Send one byte to an idle channel; sample every bit mid-period.
    task automatic send_measure(input int g, input logic [7:0] b,
                                output int nbusy,
                                output logic [11:0] bits);
        int c;
        int per;
        per   = cpb(g);
        bits  = '1;
        nbusy = 0;
        @(negedge clk);
        din[g] = b;
        vld[g] = 1'b1;
        @(negedge clk);
        vld[g] = 1'b0;
        c = 0;
        while (busy[g] && c < 20000) begin
            if (c >= 1 && (c - 1) % per == per / 2 && (c - 1) / per < 12)
                bits[(c-1)/per] = tx[g];
            nbusy++;
            c++;
            @(negedge clk);
        end
        check($sformatf("ch%0d busy bounded", g), 32'(c < 20000), 32'd1);
    endtask

    task automatic drive_rand(input int g, input int n);
        repeat (n) begin
            @(negedge clk);
            vld[g] = ($urandom_range(0, 3) != 0);
            din[g] = 8'($urandom);
        end
        @(negedge clk);
        vld[g] = 1'b0;
    endtask

    initial begin
        int          nb;
        logic [11:0] bits;
        logic [21:0] bb;
        int          c;
        int          rlow;
        int          st;

        for (int g = 0; g < 4; g++) begin
            din[g] = '0;
            vld[g] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("reset tx",    32'(tx),   32'hF);
        check("reset ready", 32'(rdy),  32'hF);
        check("reset busy",  32'(busy), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        send_measure(0, 8'h55, nb, bits);
        check("0x55 bits", 32'(bits), 32'hEAA);
        check("0x55 busy cycles", 32'(nb), 32'd4341);
        check("0x55 idle tx", 32'(tx[0]), 32'd1);

        send_measure(1, 8'h07, nb, bits);
        check("even 0x07 bits", 32'(bits), 32'hE0E);
        check("even 0x07 busy", 32'(nb), 32'd56);
        send_measure(2, 8'h07, nb, bits);
        check("odd 0x07 bits", 32'(bits), 32'hC0E);
        check("odd 0x07 busy", 32'(nb), 32'd37);
        send_measure(2, 8'h00, nb, bits);
        check("odd 0x00 bits", 32'(bits), 32'hE00);
        send_measure(3, 8'hFF, nb, bits);
        check("2stop 0xFF bits", 32'(bits), 32'hFFE);
        check("2stop 0xFF busy", 32'(nb), 32'd45);

        // Back-to-back on channel 1 (even parity, 5 clocks/bit).
        @(negedge clk);
        din[1] = 8'hA5;
        vld[1] = 1'b1;
        @(negedge clk);
        din[1] = 8'h3C;
        bb = '1;
        c = 0;
        rlow = 0;
        st = 0;
        while (busy[1] && c < 1000) begin
            if (!rdy[1]) rlow++;
            if (st == 1) begin
                vld[1] = 1'b0;
                st = 2;
            end else if (st == 0 && rdy[1]) begin
                st = 1;
            end
            if (c >= 1 && (c - 1) % 5 == 2 && (c - 1) / 5 < 22)
                bb[(c-1)/5] = tx[1];
            c++;
            @(negedge clk);
        end
        check("b2b bits", 32'(bb), 32'h23C54A);
        check("b2b busy", 32'(c), 32'd111);
        check("b2b ready low", 32'(rlow), 32'd55);

        // Reset during data bit 3 of 0x00 on channel 3.
        @(negedge clk);
        din[3] = 8'h00;
        vld[3] = 1'b1;
        @(negedge clk);
        vld[3] = 1'b0;
        repeat (1 + 4 * 4 + 1) @(negedge clk);
        check("pre-reset tx low", 32'(tx[3]), 32'd0);
        reset = 1'b1;
        #1;
        check("async reset tx",    32'(tx[3]),   32'd1);
        check("async reset busy",  32'(busy[3]), 32'd0);
        check("async reset ready", 32'(rdy[3]),  32'd1);
        @(negedge clk);
        reset = 1'b0;
        send_measure(3, 8'h81, nb, bits);
        check("post-reset 0x81 bits", 32'(bits), 32'hF02);
        check("post-reset 0x81 busy", 32'(nb), 32'd45);

        fork
            drive_rand(1, 1500);
            drive_rand(2, 1500);
            drive_rand(3, 1500);
        join
        c = 0;
        while (busy[3:1] != 3'b000 && c < 1000) begin
            c++;
            @(negedge clk);
        end
        check("drain idle", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
